// File: rtl/cpu_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl_pkg
// Brief   : Shared encodings for the CPU execution controller: front-panel
//           mode codes, controller FSM states and a state decode helper.
//           Also imported by the board top and by the bench.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_step_ctrl_pkg;

    // Front-panel mode selector encodings
    localparam logic [1:0] MODE_HALT  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;
    localparam logic [1:0] MODE_RUN   = 2'b11;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_BURST  = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    // True for every state in which the core is clocked forward
    function automatic logic is_stepping(input state_e s);
        return (s == ST_STEP) || (s == ST_BURST) || (s == ST_RUN);
    endfunction

endpackage : cpu_step_ctrl_pkg
`default_nettype wire

// File: rtl/cpu_step_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl_btn_debounce
// Brief   : Two-flop synchroniser, level debouncer and rising-edge pulse for
//           the raw push-button. A new level is accepted only after it has
//           been sampled DEBOUNCE_CYCLES times in a row; releases never pulse.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_step_ctrl_btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic btn_press_o
);

    localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q;
    logic               stable_prev_q;
    logic               press_q;
    logic [c_CNT_W-1:0] cnt_q;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that differ from the accepted level; any
    // bounce back to the accepted level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q != stable_q) begin
            if (cnt_q == c_CNT_MAX) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + c_CNT_ONE;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    // Registered one-cycle pulse on an accepted 0->1 transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_prev_q <= 1'b0;
            press_q       <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
            press_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign btn_press_o = press_q;

endmodule : cpu_step_ctrl_btn_debounce
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl
// Brief   : Execution controller between the board push-button and the CPU
//           core. Issues core clock-enable pulses in halt, single-step,
//           burst and free-run modes, counts issued steps and parks the
//           controller when the core reports a HLT.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BURST_W         = 8,
    parameter int STEP_CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_raw_i,
    input  logic [1:0]            mode_i,
    input  logic [BURST_W-1:0]    burst_len_i,
    input  logic                  halt_req_i,
    output logic                  step_en_o,
    output logic                  busy_o,
    output logic                  btn_press_o,
    output logic [STEP_CNT_W-1:0] steps_done_o
);

    localparam logic [BURST_W-1:0]    c_BURST_ONE = BURST_W'(1);
    localparam logic [STEP_CNT_W-1:0] c_STEP_ONE  = STEP_CNT_W'(1);

    logic                  press_w;
    logic                  halt_q;
    state_e                state_q;
    state_e                state_d;
    logic [BURST_W-1:0]    cnt_q;
    logic [BURST_W-1:0]    cnt_d;
    logic                  step_en_q;
    logic                  busy_q;
    logic [STEP_CNT_W-1:0] steps_q;

    cpu_step_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_i   (btn_raw_i),
        .btn_press_o (press_w)
    );

    // State, burst counter and registered outputs; outputs are loaded from
    // the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            halt_q    <= 1'b0;
            step_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            halt_q    <= halt_req_i;
            step_en_q <= is_stepping(state_d);
            busy_q    <= (state_d == ST_BURST) || (state_d == ST_RUN);
        end
    end

    // Next-state logic; a registered halt request overrides everything,
    // including a press arriving in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (halt_q) begin
            state_d = ST_HALTED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press_w && (mode_i == MODE_STEP)) begin
                        state_d = ST_STEP;
                    end else if (press_w && (mode_i == MODE_BURST)) begin
                        state_d = ST_BURST;
                        cnt_d   = (burst_len_i == '0) ? c_BURST_ONE : burst_len_i;
                    end else if (mode_i == MODE_RUN) begin
                        state_d = ST_RUN;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                end
                ST_BURST: begin
                    // Mode changes and presses do not disturb a burst
                    if (cnt_q <= c_BURST_ONE) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - c_BURST_ONE;
                    end
                end
                ST_RUN: begin
                    if (mode_i != MODE_RUN) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    // The press only releases the halt; it does not step
                    if (press_w) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Total issued steps, free-running modulo 2^STEP_CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_q <= '0;
        end else if (step_en_q) begin
            steps_q <= steps_q + c_STEP_ONE;
        end
    end

    assign step_en_o    = step_en_q;
    assign busy_o       = busy_q;
    assign btn_press_o  = press_w;
    assign steps_done_o = steps_q;

endmodule : cpu_step_ctrl
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_step_ctrl
// Brief   : Directed bench for cpu_step_ctrl (DEBOUNCE_CYCLES=4, BURST_W=8).
//           A second instance with a 4-bit step counter shares the stimulus
//           so counter wrap can be observed.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpu_step_ctrl;
    import cpu_step_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int BW  = 8;
    localparam int SW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_raw;
    logic [1:0]    mode;
    logic [BW-1:0] burst_len;
    logic          halt_req;

    logic          step_en;
    logic          busy;
    logic          btn_press;
    logic [SW-1:0] steps_done;

    logic          w_step_en;
    logic          w_busy;
    logic          w_btn_press;
    logic [3:0]    w_steps_done;

    int n_vec  = 0;
    int n_miss = 0;
    int n_step = 0;
    int n_busy = 0;
    int n_press = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BURST_W         (BW),
        .STEP_CNT_W      (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw_i    (btn_raw),
        .mode_i       (mode),
        .burst_len_i  (burst_len),
        .halt_req_i   (halt_req),
        .step_en_o    (step_en),
        .busy_o       (busy),
        .btn_press_o  (btn_press),
        .steps_done_o (steps_done)
    );

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BURST_W         (BW),
        .STEP_CNT_W      (4)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .btn_raw_i    (btn_raw),
        .mode_i       (mode),
        .burst_len_i  (burst_len),
        .halt_req_i   (halt_req),
        .step_en_o    (w_step_en),
        .busy_o       (w_busy),
        .btn_press_o  (w_btn_press),
        .steps_done_o (w_steps_done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock, then settle 1ns past the edge before anyone looks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_step  += int'(step_en);
            n_busy  += int'(busy);
            n_press += int'(btn_press);
        end
    endtask

    task automatic clr();
        n_step  = 0;
        n_busy  = 0;
        n_press = 0;
    endtask

    initial begin
        // ---- 1: reset with button held and RUN selected
        rst       = 1'b1;
        btn_raw   = 1'b1;
        mode      = MODE_RUN;
        burst_len = '0;
        halt_req  = 1'b0;
        #2;
        check("rst_step_en", int'(step_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_steps", int'(steps_done), 0);
        repeat (3) tick();
        check("rst_hold_step_en", int'(step_en), 0);
        check("rst_hold_busy", int'(busy), 0);
        check("rst_hold_press", int'(btn_press), 0);
        btn_raw = 1'b0;
        mode    = MODE_HALT;
        tick();
        rst = 1'b0;
        clr();
        run(10);
        check("idle_no_step", n_step, 0);
        check("idle_no_press", n_press, 0);

        // ---- 2: bouncy press in STEP mode
        mode = MODE_STEP;
        clr();
        btn_raw = 1'b1; run(1);
        btn_raw = 1'b0; run(1);
        btn_raw = 1'b1;                // final edge
        run(6);
        check("bounce_no_early_press", n_press, 0);
        run(1);
        check("bounce_press_at_7", int'(btn_press), 1);
        check("bounce_no_step_yet", int'(step_en), 0);
        run(1);
        check("step_pulse", int'(step_en), 1);
        check("step_press_gone", int'(btn_press), 0);
        check("step_cnt_before", int'(steps_done), 0);
        run(1);
        check("step_single", int'(step_en), 0);
        check("step_cnt_after", int'(steps_done), 1);
        run(10);
        check("bounce_one_press", n_press, 1);
        check("bounce_one_step", n_step, 1);
        btn_raw = 1'b0;
        clr();
        run(12);
        check("release_no_press", n_press, 0);
        check("release_no_step", n_step, 0);

        // ---- 3a: burst of 5
        mode      = MODE_BURST;
        burst_len = 8'd5;
        clr();
        btn_raw = 1'b1;
        run(7);
        check("burst5_press", int'(btn_press), 1);
        run(1);
        check("burst5_first_step", int'(step_en), 1);
        check("burst5_busy", int'(busy), 1);
        run(4);
        check("burst5_last_step", int'(step_en), 1);
        run(1);
        check("burst5_done_step", int'(step_en), 0);
        check("burst5_done_busy", int'(busy), 0);
        check("burst5_steps", n_step, 5);
        check("burst5_busy_cycles", n_busy, 5);
        check("burst5_total", int'(steps_done), 6);
        btn_raw = 1'b0;
        run(12);

        // ---- 3b: burst_len 0 behaves as 1
        burst_len = 8'd0;
        clr();
        btn_raw = 1'b1;
        run(20);
        check("burst0_steps", n_step, 1);
        check("burst0_total", int'(steps_done), 7);
        btn_raw = 1'b0;
        run(12);

        // ---- 3c: second press during a 20-step burst is dropped
        burst_len = 8'd20;
        clr();
        btn_raw = 1'b1;
        run(8);
        check("burst20_started", int'(step_en), 1);
        btn_raw = 1'b0;
        run(8);
        btn_raw = 1'b1;
        run(7);
        check("burst20_mid_press", int'(btn_press), 1);
        check("burst20_mid_busy", int'(busy), 1);
        run(20);
        check("burst20_steps", n_step, 20);
        check("burst20_presses", n_press, 2);
        check("burst20_total", int'(steps_done), 27);
        btn_raw = 1'b0;
        run(12);

        // ---- 4: free run, halt, resume
        mode = MODE_RUN;
        clr();
        run(10);
        check("run_steps", n_step, 10);
        check("run_busy", int'(busy), 1);
        halt_req = 1'b1;
        run(1);
        halt_req = 1'b0;
        check("halt_inflight_step", int'(step_en), 1);
        run(1);
        check("halt_step_off", int'(step_en), 0);
        check("halt_busy_off", int'(busy), 0);
        clr();
        run(5);
        check("halted_no_step", n_step, 0);
        check("halted_total", int'(steps_done), 38);
        clr();
        btn_raw = 1'b1;
        run(7);
        check("halted_press", int'(btn_press), 1);
        run(1);
        check("halted_exit_no_step", int'(step_en), 0);
        run(1);
        check("run_resume", int'(step_en), 1);
        mode = MODE_HALT;
        run(1);
        check("run_stop_no_extra", int'(step_en), 0);
        run(1);
        check("resume_steps", n_step, 1);
        check("resume_total", int'(steps_done), 39);
        btn_raw = 1'b0;
        run(12);

        // ---- 6: async reset in the middle of a long burst
        mode      = MODE_BURST;
        burst_len = 8'd200;
        clr();
        btn_raw = 1'b1;
        run(7);
        run(50);
        check("longburst_steps", n_step, 50);
        check("longburst_active", int'(step_en), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_step_en", int'(step_en), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_steps", int'(steps_done), 0);
        check("async_rst_wrap_steps", int'(w_steps_done), 0);
        btn_raw = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clr();
        run(30);
        check("post_rst_no_step", n_step, 0);
        check("post_rst_no_press", n_press, 0);
        check("post_rst_total", int'(steps_done), 0);

        // ---- 5: 17 run steps wrap a 4-bit counter to 1
        mode = MODE_RUN;
        clr();
        run(17);
        mode = MODE_HALT;
        run(1);
        check("wrap_run_steps", n_step, 17);
        check("wrap_wide_total", int'(steps_done), 17);
        check("wrap_narrow_total", int'(w_steps_done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_cpu_step_ctrl
`default_nettype wire
